// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the forwarding/hazard unit: forward-select codes and FSM state type.
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef logic [0:0] haz_state_t;

    localparam haz_state_t S_IDLE     = 1'b0;
    localparam haz_state_t S_LU_STALL = 1'b1;

    localparam int CNT_BITS = 4;

    // True when a source register is written by a stage that is allowed to forward it.
    function automatic logic rd_hits(input logic regwrite, input logic [31:0] rd, input logic [31:0] rs);
        return regwrite && (rd != 32'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_mux_sel.sv
// Per-source forward selector: EX/MEM has priority over MEM/WB, register file otherwise.
module fwd_mux_sel
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic                  ex_mem_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic                  mem_wb_regwrite,
    output logic [1:0]            sel
);

    logic ex_mem_hit;
    logic mem_wb_hit;

    assign ex_mem_hit = rd_hits(ex_mem_regwrite, 32'(ex_mem_rd), 32'(rs));
    assign mem_wb_hit = rd_hits(mem_wb_regwrite, 32'(mem_wb_rd), 32'(rs));

    always_comb begin
        sel = FWD_RF;
        if (ex_mem_hit) begin
            sel = FWD_EXMEM;
        end else if (mem_wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding selects, load-use stall FSM, dmem freeze and flush handling for the ID/EX stage.
// Optional perf counters (stall_cycles, fwd_events) are built only when HAZ_PERF_CNT_EN is defined.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no stall window open; a load-use hazard stalls this cycle
// S_LU_STALL | inside a load-use window; cnt counts remaining bubbles
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int NUM_SRC        = 2,
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] IF_ID_rs,
    input  logic [NUM_SRC-1:0]            IF_ID_rs_used,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ID_EX_rs,
    input  logic [REG_ADDR_W-1:0]         ID_EX_rd,
    input  logic [REG_ADDR_W-1:0]         EX_MEM_rd,
    input  logic [REG_ADDR_W-1:0]         MEM_WB_rd,
    input  logic                          ID_EX_memread,
    input  logic                          ID_EX_regwrite,
    input  logic                          EX_MEM_regwrite,
    input  logic                          MEM_WB_regwrite,
    input  logic                          dmem_busy,
    input  logic                          flush,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          pc_write,
    output logic                          if_id_write,
    output logic                          id_ex_bubble,
    output logic                          freeze
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]              stall_cycles,
    output logic [CNT_W-1:0]              fwd_events
`endif
);

    if (NUM_SRC < 2 || NUM_SRC > 3) begin : g_bad_num_src
        $error("hazard_forward_unit: NUM_SRC must be 2 or 3");
    end
    if (LOAD_STALL_CYC < 1 || LOAD_STALL_CYC > 15) begin : g_bad_stall_cyc
        $error("hazard_forward_unit: LOAD_STALL_CYC must be 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_forward_unit: CNT_W must be at least 1");
    end

    localparam logic [CNT_BITS-1:0] LOAD_CNT = CNT_BITS'(LOAD_STALL_CYC - 1);

    haz_state_t          state;
    haz_state_t          state_nxt;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_nxt;
    logic                src_hit;
    logic                load_use;
    logic                stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        fwd_mux_sel #(
            .REG_ADDR_W(REG_ADDR_W)
        ) u_fwd_mux_sel (
            .rs              (ID_EX_rs[i*REG_ADDR_W +: REG_ADDR_W]),
            .ex_mem_rd       (EX_MEM_rd),
            .ex_mem_regwrite (EX_MEM_regwrite),
            .mem_wb_rd       (MEM_WB_rd),
            .mem_wb_regwrite (MEM_WB_regwrite),
            .sel             (fwd_sel[2*i +: 2])
        );
    end

    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (IF_ID_rs_used[i] && (IF_ID_rs[i*REG_ADDR_W +: REG_ADDR_W] == ID_EX_rd)) begin
                src_hit = 1'b1;
            end
        end
    end

    assign load_use = ID_EX_memread && ID_EX_regwrite && (ID_EX_rd != '0) && src_hit;

    // Freeze outranks flush, flush outranks any stall.
    assign stall        = !dmem_busy && !flush && ((state == S_LU_STALL) || load_use);
    assign freeze       = dmem_busy;
    assign pc_write     = !dmem_busy && !stall;
    assign if_id_write  = !dmem_busy && !stall;
    assign id_ex_bubble = stall;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!dmem_busy) begin
            if (flush) begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (load_use) begin
                            cnt_nxt   = LOAD_CNT;
                            state_nxt = (LOAD_CNT != '0) ? S_LU_STALL : S_IDLE;
                        end
                    end
                    S_LU_STALL: begin
                        cnt_nxt = cnt - 1'b1;
                        if (cnt_nxt == '0) begin
                            state_nxt = S_IDLE;
                        end
                    end
                    default: begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic any_fwd;

    assign any_fwd = |fwd_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            if (id_ex_bubble && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (any_fwd && !freeze && (fwd_events != '1)) begin
                fwd_events <= fwd_events + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: two instances (3-cycle and 1-cycle load stall) against a behavioural model.
module tb_hazard_forward_unit;

    localparam int W    = 5;
    localparam int NS   = 2;
    localparam int LSC0 = 3;
    localparam int LSC1 = 1;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [W-1:0]    ifid_rs [NS];
    logic [W-1:0]    idex_rs [NS];
    logic [NS-1:0]   ifid_used;
    logic [W-1:0]    idex_rd, exmem_rd, memwb_rd;
    logic            idex_mr, idex_rw, exmem_rw, memwb_rw, busy, flush;
    logic [NS*W-1:0] ifid_bus, idex_bus;

    logic [2*NS-1:0] fwd0, fwd1;
    logic            pcw0, ifw0, bub0, frz0;
    logic            pcw1, ifw1, bub1, frz1;
`ifdef HAZ_PERF_CNT_EN
    logic [CW-1:0]   sc0, fe0, sc1, fe1;
    int              stall_cnt0, stall_cnt1, fwd_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int rem0    = 0;
    int rem1    = 0;

    always_comb begin
        for (int i = 0; i < NS; i++) begin
            ifid_bus[i*W +: W] = ifid_rs[i];
            idex_bus[i*W +: W] = idex_rs[i];
        end
    end

    hazard_forward_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .LOAD_STALL_CYC(LSC0), .CNT_W(CW)) u_dut0 (
        .clk(clk), .rst(rst), .IF_ID_rs(ifid_bus), .IF_ID_rs_used(ifid_used), .ID_EX_rs(idex_bus),
        .ID_EX_rd(idex_rd), .EX_MEM_rd(exmem_rd), .MEM_WB_rd(memwb_rd), .ID_EX_memread(idex_mr),
        .ID_EX_regwrite(idex_rw), .EX_MEM_regwrite(exmem_rw), .MEM_WB_regwrite(memwb_rw),
        .dmem_busy(busy), .flush(flush), .fwd_sel(fwd0), .pc_write(pcw0), .if_id_write(ifw0),
        .id_ex_bubble(bub0), .freeze(frz0)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(sc0), .fwd_events(fe0)
`endif
    );

    hazard_forward_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .LOAD_STALL_CYC(LSC1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst(rst), .IF_ID_rs(ifid_bus), .IF_ID_rs_used(ifid_used), .ID_EX_rs(idex_bus),
        .ID_EX_rd(idex_rd), .EX_MEM_rd(exmem_rd), .MEM_WB_rd(memwb_rd), .ID_EX_memread(idex_mr),
        .ID_EX_regwrite(idex_rw), .EX_MEM_regwrite(exmem_rw), .MEM_WB_regwrite(memwb_rw),
        .dmem_busy(busy), .flush(flush), .fwd_sel(fwd1), .pc_write(pcw1), .if_id_write(ifw1),
        .id_ex_bubble(bub1), .freeze(frz1)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(sc1), .fwd_events(fe1)
`endif
    );

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] m_fwd_one(input logic [W-1:0] rs);
        if (exmem_rw && exmem_rd != 0 && exmem_rd == rs) return 2'b10;
        if (memwb_rw && memwb_rd != 0 && memwb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [2*NS-1:0] m_fwd();
        logic [2*NS-1:0] v;
        for (int i = 0; i < NS; i++) v[2*i +: 2] = m_fwd_one(idex_rs[i]);
        return v;
    endfunction

    function automatic bit m_hazard();
        bit h = 0;
        if (idex_mr && idex_rw && idex_rd != 0)
            for (int i = 0; i < NS; i++)
                if (ifid_used[i] && ifid_rs[i] == idex_rd) h = 1;
        return h;
    endfunction

    // rem = bubbles still owed by the open window
    function automatic bit m_stall(input int rem);
        return !busy && !flush && (rem > 0 || m_hazard());
    endfunction

    // {pc_write, if_id_write, id_ex_bubble, freeze}
    function automatic logic [3:0] m_ctrl(input int rem);
        bit st = m_stall(rem);
        return {!busy && !st, !busy && !st, st, busy};
    endfunction

    function automatic int m_next(input int rem, input int lsc);
        if (busy)      return rem;
        if (flush)     return 0;
        if (rem > 0)   return rem - 1;
        if (m_hazard()) return lsc - 1;
        return 0;
    endfunction

`ifdef HAZ_PERF_CNT_EN
    function automatic int sat(input int v);
        return (v > (2**CW - 1)) ? (2**CW - 1) : v;
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
`ifdef HAZ_PERF_CNT_EN
        if (m_stall(rem0)) stall_cnt0++;
        if (m_stall(rem1)) stall_cnt1++;
        if (m_fwd() != 0 && !busy) fwd_cnt++;
`endif
        rem0 = m_next(rem0, LSC0);
        rem1 = m_next(rem1, LSC1);
        #1;
    endtask

    task automatic set_idle();
        for (int i = 0; i < NS; i++) begin
            ifid_rs[i] = 5'd0;
            idex_rs[i] = 5'd0;
        end
        ifid_used = '0;
        idex_rd = 0; exmem_rd = 0; memwb_rd = 0;
        idex_mr = 0; idex_rw = 0; exmem_rw = 0; memwb_rw = 0;
        busy = 0; flush = 0;
    endtask

    task automatic set_load7();
        idex_mr = 1; idex_rw = 1; idex_rd = 5'd7;
        ifid_rs[1] = 5'd7; ifid_used[1] = 1'b1;
    endtask

    task automatic set_bubble_in_ex();
        idex_mr = 0; idex_rw = 0; idex_rd = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rem0 = 0; rem1 = 0;
`ifdef HAZ_PERF_CNT_EN
        stall_cnt0 = 0; stall_cnt1 = 0; fwd_cnt = 0;
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        exmem_rd = 5'd3; memwb_rd = 5'd4; idex_rs[0] = 5'd3; idex_rs[1] = 5'd4;
        @(negedge clk);
        n_tests++;
        if ({pcw0, ifw0, bub0, frz0, fwd0} !== {4'b1100, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_dut0: got ctrl=%b fwd=%b, want ctrl=1100 fwd=0000", {pcw0, ifw0, bub0, frz0}, fwd0);
        end
        n_tests++;
        if ({pcw1, ifw1, bub1, frz1, fwd1} !== {4'b1100, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_dut1: got ctrl=%b fwd=%b, want ctrl=1100 fwd=0000", {pcw1, ifw1, bub1, frz1}, fwd1);
        end
`ifdef HAZ_PERF_CNT_EN
        n_tests++;
        if ({sc0, fe0, sc1, fe1} !== '0) begin
            n_fail++;
            $display("FAIL reset_perf: got sc0=%0d fe0=%0d sc1=%0d fe1=%0d, want all 0", sc0, fe0, sc1, fe1);
        end
`endif
        do_reset();
    endtask

    task automatic test_forward();
        set_idle();
        idex_rs[0] = 5'd5; exmem_rd = 5'd5; exmem_rw = 1; memwb_rd = 5'd5; memwb_rw = 1;
        #1;
        n_tests++;
        if (fwd0[1:0] !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_exmem_prio: got %b, want 10", fwd0[1:0]);
        end
        exmem_rw = 0;
        #1;
        n_tests++;
        if (fwd0[1:0] !== 2'b01) begin
            n_fail++;
            $display("FAIL fwd_memwb: got %b, want 01", fwd0[1:0]);
        end
        exmem_rw = 1; exmem_rd = 0; memwb_rd = 0; idex_rs[0] = 0; idex_rs[1] = 0;
        #1;
        n_tests++;
        if (fwd0 !== 4'b0000) begin
            n_fail++;
            $display("FAIL fwd_x0: got %b, want 0000", fwd0);
        end
        idex_rs[1] = 5'd9; memwb_rd = 5'd9; exmem_rd = 5'd2;
        #1;
        n_tests++;
        if (fwd1 !== 4'b0100) begin
            n_fail++;
            $display("FAIL fwd_src1: got %b, want 0100", fwd1);
        end
        set_idle();
        tick();
    endtask

    task automatic test_load_use();
        int bub_n0 = 0, bub_n1 = 0, first0 = -1, last0 = -1;
        set_idle();
        for (int c = 0; c < 7; c++) begin
            if (c == 0) set_load7();
            else begin
                set_bubble_in_ex();
                memwb_rd = 5'd7; memwb_rw = 1;
            end
            @(negedge clk);
            if (bub0 && !pcw0) begin
                bub_n0++;
                if (first0 < 0) first0 = c;
                last0 = c;
            end
            if (bub1 && !pcw1) bub_n1++;
            tick();
        end
        n_tests++;
        if (bub_n0 !== LSC0 || first0 !== 0 || last0 !== LSC0 - 1) begin
            n_fail++;
            $display("FAIL load_use_window0: got n=%0d first=%0d last=%0d, want n=%0d first=0 last=%0d",
                     bub_n0, first0, last0, LSC0, LSC0 - 1);
        end
        n_tests++;
        if (bub_n1 !== LSC1) begin
            n_fail++;
            $display("FAIL load_use_window1: got n=%0d, want %0d", bub_n1, LSC1);
        end
        ifid_used = 0; idex_rs[1] = 5'd7;
        @(negedge clk);
        n_tests++;
        if (fwd0[3:2] !== 2'b01 || pcw0 !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_consumer: got fwd=%b pcw=%b, want fwd=01 pcw=1", fwd0[3:2], pcw0);
        end
        set_idle();
        tick();
    endtask

    task automatic test_freeze();
        int bub_n0 = 0, frz_n0 = 0, bub_n1 = 0, frz_n1 = 0, first0 = -1, last0 = -1;
        set_idle();
        for (int c = 0; c < 9; c++) begin
            if (c == 0) set_load7();
            else set_bubble_in_ex();
            busy = (c == 1 || c == 2);
            @(negedge clk);
            if (bub0) begin
                bub_n0++;
                if (first0 < 0) first0 = c;
                last0 = c;
            end
            if (frz0 && !pcw0 && !bub0) frz_n0++;
            if (bub1) bub_n1++;
            if (frz1 && !bub1) frz_n1++;
            tick();
        end
        n_tests++;
        if (bub_n0 !== 3 || frz_n0 !== 2 || last0 - first0 + 1 !== 5) begin
            n_fail++;
            $display("FAIL freeze_window0: got bub=%0d frz=%0d span=%0d, want bub=3 frz=2 span=5",
                     bub_n0, frz_n0, last0 - first0 + 1);
        end
        n_tests++;
        if (bub_n1 !== 1 || frz_n1 !== 2) begin
            n_fail++;
            $display("FAIL freeze_window1: got bub=%0d frz=%0d, want bub=1 frz=2", bub_n1, frz_n1);
        end
        set_idle();
        tick();
    endtask

    task automatic test_flush();
        logic [3:0] got [9];
        logic [3:0] want [9];
        want = '{4'b1100, 4'b1100, 4'b0010, 4'b1100, 4'b1100, 4'b0010, 4'b0001, 4'b1100, 4'b1100};
        set_idle();
        for (int c = 0; c < 9; c++) begin
            set_bubble_in_ex();
            if (c == 0 || c == 2 || c == 5) set_load7();
            flush = (c == 0 || c == 3 || c == 6 || c == 7);
            busy  = (c == 6);
            @(negedge clk);
            got[c] = {pcw0, ifw0, bub0, frz0};
            tick();
        end
        for (int c = 0; c < 9; c++) begin
            n_tests++;
            if (got[c] !== want[c]) begin
                n_fail++;
                $display("FAIL flush_c%0d: got ctrl=%b, want %b", c, got[c], want[c]);
            end
        end
        set_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        set_idle();
        set_load7();
        tick();
        set_bubble_in_ex();
        @(negedge clk);
        n_tests++;
        if (bub0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_prestall: got bub=%b, want 1", bub0);
        end
        #1 rst = 1'b1;
        #1;
        n_tests++;
        if ({pcw0, ifw0, bub0, frz0} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_mid_async: got ctrl=%b, want 1100", {pcw0, ifw0, bub0, frz0});
        end
        do_reset();
        @(negedge clk);
        n_tests++;
        if (bub0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got bub=%b, want 0", bub0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int miss = 0;
        do_reset();
        set_load7();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!bub0 || !bub1) miss++;
            tick();
        end
        n_tests++;
        if (miss !== 0) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d non-stall cycles, want 0", miss);
        end
`ifdef HAZ_PERF_CNT_EN
        n_tests++;
        if (sc0 !== 4'd15 || sc1 !== 4'd15 || fe0 !== 4'd0) begin
            n_fail++;
            $display("FAIL perf_saturate: got sc0=%0d sc1=%0d fe0=%0d, want 15 15 0", sc0, sc1, fe0);
        end
`endif
        set_idle();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if (c % 40 == 0) do_reset();
            for (int i = 0; i < NS; i++) begin
                ifid_rs[i] = 5'($urandom_range(0, 3));
                idex_rs[i] = 5'($urandom_range(0, 3));
            end
            ifid_used = NS'($urandom_range(0, 2**NS - 1));
            idex_rd  = 5'($urandom_range(0, 3));
            exmem_rd = 5'($urandom_range(0, 3));
            memwb_rd = 5'($urandom_range(0, 3));
            idex_mr  = 1'($urandom_range(0, 1));
            idex_rw  = ($urandom_range(0, 3) != 0);
            exmem_rw = 1'($urandom_range(0, 1));
            memwb_rw = 1'($urandom_range(0, 1));
            busy     = ($urandom_range(0, 6) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            n_tests++;
            if (fwd0 !== m_fwd() || fwd1 !== m_fwd()) begin
                n_fail++;
                $display("FAIL rnd_fwd c%0d: got %b/%b, want %b", c, fwd0, fwd1, m_fwd());
            end
            n_tests++;
            if ({pcw0, ifw0, bub0, frz0} !== m_ctrl(rem0)) begin
                n_fail++;
                $display("FAIL rnd_ctrl0 c%0d: got %b, want %b", c, {pcw0, ifw0, bub0, frz0}, m_ctrl(rem0));
            end
            n_tests++;
            if ({pcw1, ifw1, bub1, frz1} !== m_ctrl(rem1)) begin
                n_fail++;
                $display("FAIL rnd_ctrl1 c%0d: got %b, want %b", c, {pcw1, ifw1, bub1, frz1}, m_ctrl(rem1));
            end
`ifdef HAZ_PERF_CNT_EN
            n_tests++;
            if (sc0 !== CW'(sat(stall_cnt0)) || sc1 !== CW'(sat(stall_cnt1)) ||
                fe0 !== CW'(sat(fwd_cnt)) || fe1 !== CW'(sat(fwd_cnt))) begin
                n_fail++;
                $display("FAIL rnd_perf c%0d: got sc=%0d/%0d fe=%0d/%0d, want sc=%0d/%0d fe=%0d", c,
                         sc0, sc1, fe0, fe1, sat(stall_cnt0), sat(stall_cnt1), sat(fwd_cnt));
            end
`endif
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_forward();
        test_load_use();
        test_freeze();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised forwarding and hazard unit for the RV32IC pipeline. It sits beside the ID/EX stage and drives ALU operand forward selects for NUM_SRC source ports from both EX/MEM and MEM/WB. It also detects load-use hazards and holds a multi-cycle load-stall state machine for data memories with LOAD_STALL_CYC latency. It honours a data-memory busy freeze and branch flushes.

## Interface
- REG_ADDR_W, 5, register address width
- NUM_SRC, 2, number of source operands checked (2 or 3)
- LOAD_STALL_CYC, 1, bubbles inserted per load-use hazard (1..15)
- CNT_W, 32, performance counter width (only with HAZ_PERF_CNT_EN)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- IF_ID_rs  in  NUM_SRC*REG_ADDR_W  source regs of instruction in ID, source i at bits [i*REG_ADDR_W +: REG_ADDR_W]
- IF_ID_rs_used  in  NUM_SRC  bit i set when source i is really read
- ID_EX_rs  in  NUM_SRC*REG_ADDR_W  source regs of instruction in EX
- ID_EX_rd, EX_MEM_rd, MEM_WB_rd  in  REG_ADDR_W  destination regs per stage
- ID_EX_memread  in  1  EX instruction is a load
- ID_EX_regwrite, EX_MEM_regwrite, MEM_WB_regwrite  in  1  stage writes rd
- dmem_busy  in  1  data memory not ready, whole pipeline must hold
- flush  in  1  branch/jump taken, IF/ID squashed this cycle
- fwd_sel  out  2*NUM_SRC  per source: 00 regfile, 10 EX/MEM, 01 MEM/WB
- pc_write  out  1  PC may update
- if_id_write  out  1  IF/ID may update
- id_ex_bubble  out  1  load a NOP into ID/EX
- freeze  out  1  hold every pipeline register
- stall_cycles, fwd_events  out  CNT_W  perf counters (only with HAZ_PERF_CNT_EN)

## Operation
- Forwarding is combinational, per source i. EX/MEM match: EX_MEM_regwrite, EX_MEM_rd != 0, EX_MEM_rd == ID_EX_rs[i] -> 10.
- Otherwise MEM/WB match with the same rules -> 01. Otherwise 00. EX/MEM has priority.
- Hazard condition: ID_EX_memread, ID_EX_regwrite, ID_EX_rd != 0, and some i with IF_ID_rs_used[i] and IF_ID_rs[i] == ID_EX_rd.
- FSM states: IDLE, LU_STALL. Down-counter cnt is 4 bits.
- IDLE with hazard and no flush: stall this cycle. Load cnt = LOAD_STALL_CYC-1. Go to LU_STALL if cnt != 0, else stay in IDLE.
- LU_STALL: stall. Decrement cnt. Return to IDLE when cnt reaches 0 after the decrement.
- Stall means pc_write=0, if_id_write=0, id_ex_bubble=1.
- flush wins over everything except freeze. No stall is asserted, FSM goes to IDLE, cnt is cleared.
- dmem_busy: freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0. FSM state and cnt hold. fwd_sel is still computed.
- Simultaneous dmem_busy and flush: freeze applies, and the flush is applied in the first cycle busy is low. The pipeline holds flush asserted, and this unit does not latch it.

## Timing
- fwd_sel, freeze, and stall outputs are combinational from inputs and current state, with zero-cycle latency.
- A hazard seen in cycle N gives exactly LOAD_STALL_CYC consecutive stall cycles, N..N+LOAD_STALL_CYC-1, excluding frozen cycles, which extend the window.
- Reset values: state=IDLE, cnt=0, perf counters 0. Outputs then read pc_write=1, if_id_write=1, id_ex_bubble=0, freeze=0, fwd_sel=0 for non-matching inputs.
- Reset mid-stall aborts immediately and asynchronously to IDLE.
- Hazard re-detected on the cycle the FSM returns to IDLE starts a fresh window (back-to-back loads).

## Configuration
- HAZ_PERF_CNT_EN defined: stall_cycles increments on every cycle with id_ex_bubble=1. fwd_events increments by 1 on each cycle with any fwd_sel != 00 and freeze=0.
- Both counters saturate at all-ones and reset to 0 on rst.
- HAZ_PERF_CNT_EN undefined: counters and ports are absent, and behaviour is otherwise identical.

## Structure
- Shared package holds the fwd_sel encodings FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01, and the FSM state typedef.
- One sub-module: fwd_mux_sel, a combinational per-source priority selector instantiated NUM_SRC times by generate.

## Test plan
- EX/MEM rd=5, regwrite=1, ID_EX_rs0=5; MEM/WB rd=5 too -> fwd_sel[1:0]=10. Same with EX_MEM_regwrite=0 -> 01.
- rd=0 in both stages matching rs=0 -> fwd_sel=00.
- Load rd=7 in EX, IF_ID_rs1=7 used, LOAD_STALL_CYC=3 -> exactly 3 cycles of pc_write=0 and id_ex_bubble=1, then normal flow with fwd_sel=01 on the consumer.
- Same hazard with dmem_busy high for 2 cycles inside the window -> freeze=1 for those 2 cycles, total stall window of 5 cycles, bubbles=3.
- Hazard and flush in the same cycle -> no stall, FSM stays in IDLE. rst asserted mid-window -> outputs return to reset values without waiting for a clock edge.
- With HAZ_PERF_CNT_EN and CNT_W=4: force 20 stall cycles -> stall_cycles=15 (saturated).
